// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
//   Shared definitions for the iterative shift-add multiplier.
//   - MUL_WIDTH          : operand width (product is twice this)
//   - MUL_SETTLE_DEFAULT : default adder settle cycles per iteration
//   - mul_state_t        : controller states
//   - mul_flags_t        : result status flags (zero / negative / high-half)
package mul_seq_pkg;

    localparam int unsigned MUL_WIDTH          = 32;
    localparam int unsigned MUL_SETTLE_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
    } mul_flags_t;

    // A zero product is the reset result, so Z starts set.
    localparam mul_flags_t MUL_FLAGS_RESET = '{z: 1'b1, n: 1'b0, h: 1'b0};

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Controller for mul_seq: FSM, adder settle counter and iteration counter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : multiply request, only honoured in IDLE
//     accept     : start taken this cycle (datapath loads operands)
//     iter_en    : in ITER, datapath drives the adder
//     commit     : adder result is settled, datapath shifts it in
//     last       : this commit is the final iteration
//     busy, done : handshake outputs decoded from the state register
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = MUL_WIDTH,
    parameter int unsigned SETTLE = MUL_SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic accept,
    output logic iter_en,
    output logic commit,
    output logic last,
    output logic busy,
    output logic done
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    localparam logic [5:0] IT_LAST  = 6'(WIDTH - 1);

    mul_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] it_q, it_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            it_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            it_q    <= it_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        it_d    = it_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    cnt_d   = 4'd0;
                    it_d    = 6'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (commit) begin
                    cnt_d = 4'd0;
                    it_d  = it_q + 6'd1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Always a single cycle; a held start is seen again in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                it_d    = 6'd0;
            end
        endcase
    end

    // Output decode from the current state only.
    always_comb begin
        accept  = 1'b0;
        iter_en = 1'b0;
        commit  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start;
            end
            ITER: begin
                iter_en = 1'b1;
                busy    = 1'b1;
                commit  = (cnt_q == CNT_LAST);
                last    = (cnt_q == CNT_LAST) && (it_q == IT_LAST);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mul_seq.sv
// mul_seq
//   Iterative unsigned shift-add multiplier built around an external ripple
//   adder. One product bit is retired per iteration; each iteration waits
//   SETTLE cycles for the adder before committing its sum.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start, op_a, op_b   : request and operands (captured on accept)
//     busy, done          : handshake (busy while iterating, done pulse)
//     prod, flag_Z/N/H    : product and status, held until the next result
//     add_a, add_b, add_cin : drive the external adder
//     add_s, add_cout     : result from the external adder
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = MUL_WIDTH,
    parameter int unsigned SETTLE = MUL_SETTLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 flag_Z,
    output logic                 flag_N,
    output logic                 flag_H,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);

    logic accept;
    logic iter_en;
    logic commit;
    logic last;

    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    mul_flags_t         flags_q, flags_d;

    logic [WIDTH-1:0]   hi_step;
    logic [WIDTH-1:0]   lo_step;

    function automatic mul_flags_t calc_flags(input logic [2*WIDTH-1:0] p);
        mul_flags_t f;
        f.z = (p == {(2*WIDTH){1'b0}});
        f.n = p[2*WIDTH-1];
        f.h = (p[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        return f;
    endfunction

    mul_seq_ctrl #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .accept  (accept),
        .iter_en (iter_en),
        .commit  (commit),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            flags_q <= MUL_FLAGS_RESET;
        end else begin
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            flags_q <= flags_d;
        end
    end

    // Accumulator update: the adder carry becomes the new top bit of hi and
    // the bit shifted out of the sum enters lo from the top, so the whole
    // 2*WIDTH accumulator shifts right by one per commit with nothing lost.
    always_comb begin
        hi_step = {add_cout, add_s[WIDTH-1:1]};
        lo_step = {add_s[0], lo_q[WIDTH-1:1]};
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        flags_d = flags_q;
        if (accept) begin
            m_d  = op_a;
            hi_d = {WIDTH{1'b0}};
            lo_d = op_b;
        end else if (commit) begin
            hi_d = hi_step;
            lo_d = lo_step;
            if (last) begin
                prod_d  = {hi_step, lo_step};
                flags_d = calc_flags({hi_step, lo_step});
            end else begin
                prod_d  = prod_q;
                flags_d = flags_q;
            end
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // Adder drive: add M when the current multiplier bit is set, else pass hi.
    always_comb begin
        if (iter_en) begin
            add_a = hi_q;
            add_b = lo_q[0] ? m_q : {WIDTH{1'b0}};
        end else begin
            add_a = {WIDTH{1'b0}};
            add_b = {WIDTH{1'b0}};
        end
    end

    assign add_cin = 1'b0;
    assign prod    = prod_q;
    assign flag_Z  = flags_q.z;
    assign flag_N  = flags_q.n;
    assign flag_H  = flags_q.h;

endmodule
